// File: rtl/fir_tdm_if.sv
// ---------------------------------------------------------------------------
// fir_tdm_if
// Handshake and data bundle between a sample/coefficient producer and
// fir_tdm_core.
//
// Signals:
//   x_in       signed input sample (BW_in)
//   x_valid    producer offers x_in
//   x_ready    core accepts x_in on this edge if x_valid is also high
//   coef_in    signed coefficient word (BW_coef)
//   coef_load  shift coef_in into the coefficient register file
//   y_out      signed filtered output (BW_out), held between results
//   y_valid    one-cycle strobe, y_out carries a new result this cycle
//
// Modports:
//   master  producer / consumer side
//   slave   filter core side
// ---------------------------------------------------------------------------
interface fir_tdm_if #(
    parameter int BW_in   = 2,
    parameter int BW_coef = 4,
    parameter int BW_out  = 8
);
    logic signed [BW_in-1:0]   x_in;
    logic                      x_valid;
    logic                      x_ready;
    logic signed [BW_coef-1:0] coef_in;
    logic                      coef_load;
    logic signed [BW_out-1:0]  y_out;
    logic                      y_valid;

    modport master (
        output x_in, x_valid, coef_in, coef_load,
        input  x_ready, y_out, y_valid
    );

    modport slave (
        input  x_in, x_valid, coef_in, coef_load,
        output x_ready, y_out, y_valid
    );
endinterface

// File: rtl/fir_tdm_core.sv
// ---------------------------------------------------------------------------
// fir_tdm_core
// Time-multiplexed signed FIR filter. One multiply-accumulate unit walks all
// N_TAPS taps, one tap per clock, after each accepted sample. Coefficients
// are loaded serially; the result is shifted, saturated and strobed out.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   bus        fir_tdm_if.slave: sample in, coefficient load, result out
//   dbg_state  current FSM state (0 = IDLE, 1 = MAC)
//
// Handshake: a sample transfers on a rising edge where x_valid && x_ready.
// x_ready = IDLE && !coef_load; it is not held off by x_valid. An offered
// sample that sees x_ready low is not captured and the producer must keep
// it on x_in. y_valid is a single-cycle strobe with no back-pressure; y_out
// holds its value until the next strobe.
// ---------------------------------------------------------------------------
module fir_tdm_core #(
    parameter int N_TAPS  = 4,
    parameter int BW_in   = 2,
    parameter int BW_coef = 4,
    parameter int BW_out  = 8,
    parameter int SHIFT   = 0
) (
    input  logic       clk,
    input  logic       rst,
    fir_tdm_if.slave   bus,
    output logic       dbg_state
);

    // Wide enough that a full sum of N_TAPS worst-case products never wraps.
    localparam int ACC_W = BW_in + BW_coef + $clog2(N_TAPS);
    localparam int IDX_W = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;

    localparam logic signed [ACC_W-1:0] ONE     = ACC_W'(1);
    // With BW_out == ACC_W the shift lands on the sign bit and the
    // subtraction wraps to the largest positive value, which is intended.
    localparam logic signed [ACC_W-1:0] OUT_MAX = (ONE <<< (BW_out - 1)) - ONE;
    localparam logic signed [ACC_W-1:0] OUT_MIN = -OUT_MAX - ONE;
    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(N_TAPS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        MAC  = 1'b1
    } state_t;

    state_t state;
    state_t state_nx;

    logic signed [BW_in-1:0]   d_line [N_TAPS];
    logic signed [BW_coef-1:0] c_reg  [N_TAPS];
    logic signed [ACC_W-1:0]   acc;
    logic [IDX_W-1:0]          tap_idx;
    logic signed [BW_out-1:0]  y_out_r;
    logic                      y_valid_r;

    logic                      accept;
    logic                      last_tap;
    logic signed [ACC_W-1:0]   c_ext;
    logic signed [ACC_W-1:0]   d_ext;
    logic signed [ACC_W-1:0]   prod;
    logic signed [ACC_W-1:0]   acc_sum;
    logic signed [ACC_W-1:0]   acc_shift;
    logic signed [ACC_W-1:0]   y_clamp;

    assign bus.x_ready = (state == IDLE) && !bus.coef_load;
    assign bus.y_out   = y_out_r;
    assign bus.y_valid = y_valid_r;
    assign dbg_state   = (state == MAC);

    assign accept   = bus.x_valid && bus.x_ready;
    assign last_tap = (tap_idx == LAST_IDX);

    // MAC datapath: operands sign-extended to the accumulator width so the
    // product and running sum stay exact.
    always_comb begin
        c_ext     = ACC_W'(c_reg[tap_idx]);
        d_ext     = ACC_W'(d_line[tap_idx]);
        prod      = c_ext * d_ext;
        acc_sum   = acc + prod;
        acc_shift = acc_sum >>> SHIFT;
        y_clamp   = acc_shift;
        if (acc_shift > OUT_MAX) begin
            y_clamp = OUT_MAX;
        end else if (acc_shift < OUT_MIN) begin
            y_clamp = OUT_MIN;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next state
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept)   state_nx = MAC;
            MAC:  if (last_tap) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Delay line, coefficient file, accumulator and output register
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_TAPS; k++) begin
                d_line[k] <= '0;
                c_reg[k]  <= '0;
            end
            acc       <= '0;
            tap_idx   <= '0;
            y_out_r   <= '0;
            y_valid_r <= 1'b0;
        end else begin
            y_valid_r <= 1'b0;
            if (state == IDLE) begin
                // coef_load has priority: it also forces x_ready low, so
                // accept and a coefficient shift never coincide.
                if (bus.coef_load) begin
                    for (int k = 0; k < N_TAPS - 1; k++) begin
                        c_reg[k] <= c_reg[k+1];
                    end
                    c_reg[N_TAPS-1] <= bus.coef_in;
                end
                if (accept) begin
                    for (int k = N_TAPS - 1; k > 0; k--) begin
                        d_line[k] <= d_line[k-1];
                    end
                    d_line[0] <= bus.x_in;
                    acc       <= '0;
                    tap_idx   <= '0;
                end
            end else begin
                acc     <= acc_sum;
                tap_idx <= tap_idx + 1'b1;
                if (last_tap) begin
                    tap_idx   <= '0;
                    y_out_r   <= y_clamp[BW_out-1:0];
                    y_valid_r <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_tdm_core.sv
// ---------------------------------------------------------------------------
// tb_fir_tdm_core
// Three filter instances share clock, reset and stimulus:
//   dut_a  BW_out=8, SHIFT=0
//   dut_s  BW_out=4, SHIFT=0  (saturating output)
//   dut_h  BW_out=8, SHIFT=2
// An integer reference filter produces the expected outputs of all three.
// ---------------------------------------------------------------------------
module tb_fir_tdm_core;

    localparam int N = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic signed [1:0] x_in;
    logic              x_valid;
    logic signed [3:0] coef_in;
    logic              coef_load;
    logic              dbg_a, dbg_s, dbg_h;

    fir_tdm_if #(.BW_in(2), .BW_coef(4), .BW_out(8)) if_a ();
    fir_tdm_if #(.BW_in(2), .BW_coef(4), .BW_out(4)) if_s ();
    fir_tdm_if #(.BW_in(2), .BW_coef(4), .BW_out(8)) if_h ();

    assign if_a.x_in = x_in;  assign if_a.x_valid = x_valid;
    assign if_a.coef_in = coef_in;  assign if_a.coef_load = coef_load;
    assign if_s.x_in = x_in;  assign if_s.x_valid = x_valid;
    assign if_s.coef_in = coef_in;  assign if_s.coef_load = coef_load;
    assign if_h.x_in = x_in;  assign if_h.x_valid = x_valid;
    assign if_h.coef_in = coef_in;  assign if_h.coef_load = coef_load;

    fir_tdm_core #(.N_TAPS(N), .BW_in(2), .BW_coef(4), .BW_out(8), .SHIFT(0))
        dut_a (.clk(clk), .rst(rst), .bus(if_a), .dbg_state(dbg_a));
    fir_tdm_core #(.N_TAPS(N), .BW_in(2), .BW_coef(4), .BW_out(4), .SHIFT(0))
        dut_s (.clk(clk), .rst(rst), .bus(if_s), .dbg_state(dbg_s));
    fir_tdm_core #(.N_TAPS(N), .BW_in(2), .BW_coef(4), .BW_out(8), .SHIFT(2))
        dut_h (.clk(clk), .rst(rst), .bus(if_h), .dbg_state(dbg_h));

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // ---------------- reference model / scoreboard ----------------
    int mc [N];
    int md [N];
    logic [7:0] exp_q_a [$];
    logic [3:0] exp_q_s [$];
    logic [7:0] exp_q_h [$];

    function automatic int sat_shift(input int sum, input int sh, input int bw);
        int v;
        int hi;
        int lo;
        v  = sum >>> sh;
        hi = (1 << (bw - 1)) - 1;
        lo = -(1 << (bw - 1));
        if (v > hi) v = hi;
        if (v < lo) v = lo;
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            mc[k] = 0;
            md[k] = 0;
        end
        exp_q_a.delete();
        exp_q_s.delete();
        exp_q_h.delete();
    endtask

    task automatic model_load(input int c);
        for (int k = 0; k < N - 1; k++) mc[k] = mc[k+1];
        mc[N-1] = c;
    endtask

    task automatic model_accept(input int x);
        int sum;
        for (int k = N - 1; k > 0; k--) md[k] = md[k-1];
        md[0] = x;
        sum = 0;
        for (int k = 0; k < N; k++) sum += mc[k] * md[k];
        exp_q_a.push_back(8'(sat_shift(sum, 0, 8)));
        exp_q_s.push_back(4'(sat_shift(sum, 0, 4)));
        exp_q_h.push_back(8'(sat_shift(sum, 2, 8)));
    endtask

    // Output monitors: every strobe must match the oldest expected result.
    always @(negedge clk) begin
        if (!rst && if_a.y_valid) begin
            check("y_a_pending", int'(exp_q_a.size() > 0), 1);
            if (exp_q_a.size() > 0)
                check("y_a", int'($signed(if_a.y_out)), int'($signed(exp_q_a.pop_front())));
        end
    end

    always @(negedge clk) begin
        if (!rst && if_s.y_valid) begin
            check("y_s_pending", int'(exp_q_s.size() > 0), 1);
            if (exp_q_s.size() > 0)
                check("y_s", int'($signed(if_s.y_out)), int'($signed(exp_q_s.pop_front())));
        end
    end

    always @(negedge clk) begin
        if (!rst && if_h.y_valid) begin
            check("y_h_pending", int'(exp_q_h.size() > 0), 1);
            if (exp_q_h.size() > 0)
                check("y_h", int'($signed(if_h.y_out)), int'($signed(exp_q_h.pop_front())));
        end
    end

    // ---------------- driver tasks (entered and left on a falling edge) ----
    task automatic load_coef(input int c, input bit applies);
        coef_in   = 4'(c);
        coef_load = 1'b1;
        @(posedge clk);
        if (applies) model_load(c);
        @(negedge clk);
        coef_load = 1'b0;
    endtask

    task automatic load_set(input int c0, input int c1, input int c2, input int c3);
        load_coef(c0, 1'b1);
        load_coef(c1, 1'b1);
        load_coef(c2, 1'b1);
        load_coef(c3, 1'b1);
    endtask

    task automatic send_sample(input int x);
        bit done;
        done    = 1'b0;
        x_in    = 2'(x);
        x_valid = 1'b1;
        for (int t = 0; t < 50 && !done; t++) begin
            #1;
            if (if_a.x_ready) begin
                @(posedge clk);
                model_accept(x);
                done = 1'b1;
            end
            @(negedge clk);
        end
        x_valid = 1'b0;
        check("accept_timeout", int'(done), 1);
    endtask

    // Keeps x_valid high across samples and measures the accept spacing.
    task automatic stream3(input int x0, input int x1, input int x2);
        int  xs [3];
        longint last_t;
        bit  found;
        xs[0] = x0; xs[1] = x1; xs[2] = x2;
        last_t  = -1;
        x_valid = 1'b1;
        for (int s = 0; s < 3; s++) begin
            x_in  = 2'(xs[s]);
            found = 1'b0;
            for (int t = 0; t < 20 && !found; t++) begin
                #1;
                if (if_a.x_ready) begin
                    @(posedge clk);
                    model_accept(xs[s]);
                    if (last_t >= 0) check("stream_period", int'(($time - last_t) / 10), N + 1);
                    last_t = $time;
                    found  = 1'b1;
                end
                @(negedge clk);
            end
            check("stream_timeout", int'(found), 1);
        end
        x_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && (exp_q_a.size() + exp_q_s.size() + exp_q_h.size()) != 0; t++) begin
            @(negedge clk);
            #2;
        end
        @(negedge clk);
        check("drain", exp_q_a.size() + exp_q_s.size() + exp_q_h.size(), 0);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_y_a"},   int'(if_a.y_out), 0);
        check({tag, "_y_s"},   int'(if_s.y_out), 0);
        check({tag, "_y_h"},   int'(if_h.y_out), 0);
        check({tag, "_vld"},   int'(if_a.y_valid | if_s.y_valid | if_h.y_valid), 0);
        check({tag, "_ready"}, int'(if_a.x_ready), 1);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        rst       = 1'b1;
        x_in      = '0;
        x_valid   = 1'b0;
        coef_in   = '0;
        coef_load = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("rst0");
        @(negedge clk);

        // Impulse with all-zero coefficients
        send_sample(1);
        drain();

        // Coefficients 1,2,3,4: impulse and scaled impulse
        load_set(1, 2, 3, 4);
        send_sample(1);
        for (int k = 0; k < 4; k++) send_sample(0);
        send_sample(-2);
        for (int k = 0; k < 3; k++) send_sample(0);
        drain();

        // Latency / handshake, then back-to-back result cycle accept
        x_in    = 2'(1);
        x_valid = 1'b1;
        #1;
        check("lat_ready0", int'(if_a.x_ready), 1);
        @(posedge clk);
        model_accept(1);
        for (int k = 0; k <= N; k++) begin
            @(negedge clk);
            x_valid = 1'b0;
            check("lat_ready", int'(if_a.x_ready), int'(k == N));
            check("lat_valid", int'(if_a.y_valid), int'(k == N));
        end
        x_in    = 2'(-1);
        x_valid = 1'b1;
        @(posedge clk);
        model_accept(-1);
        @(negedge clk);
        x_valid = 1'b0;
        drain();
        stream3(1, 0, -1);
        drain();

        // Saturation / shift: coefficients all 7
        load_set(7, 7, 7, 7);
        for (int k = 0; k < 4; k++) send_sample(1);
        for (int k = 0; k < 4; k++) send_sample(-2);
        drain();

        // coef_load during MAC is ignored
        load_set(1, 2, 3, 4);
        for (int k = 0; k < 4; k++) send_sample(0);
        drain();
        x_in    = 2'(1);
        x_valid = 1'b1;
        #1;
        @(posedge clk);
        model_accept(1);
        @(negedge clk);
        x_valid   = 1'b0;
        coef_in   = 4'(5);
        coef_load = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("mac_load_ready", int'(if_a.x_ready), 0);
            @(negedge clk);
        end
        coef_load = 1'b0;
        for (int k = 0; k < 4; k++) send_sample(0);
        drain();

        // coef_load and x_valid together in IDLE: shift wins, sample held off
        coef_in   = 4'(-1);
        coef_load = 1'b1;
        x_in      = 2'(1);
        x_valid   = 1'b1;
        #1;
        check("both_ready", int'(if_a.x_ready), 0);
        @(posedge clk);
        model_load(-1);
        @(negedge clk);
        coef_load = 1'b0;
        x_valid   = 1'b0;
        idle_cycles(8);
        send_sample(1);
        for (int k = 0; k < 3; k++) send_sample(0);
        drain();

        // Reset in the second MAC cycle
        for (int k = 0; k < 4; k++) send_sample(1);
        drain();
        x_in    = 2'(1);
        x_valid = 1'b1;
        #1;
        @(posedge clk);
        model_accept(1);
        @(negedge clk);
        x_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        idle_cycles(2);
        rst = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        @(negedge clk);
        idle_cycles(8);
        check("rst_mid_y_a_hold", int'(if_a.y_out), 0);
        load_set(1, 2, 3, 4);
        send_sample(1);
        for (int k = 0; k < 3; k++) send_sample(0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fir_tdm_core.md
Name: fir_tdm_core

Overview:
Parametrised, time-multiplexed signed FIR filter core. It succeeds the fixed single-tap filter behind gbsha_top, and is the next-generation datapath behind the 8-bit io_in/io_out pin wrapper. A single multiply-accumulate unit is shared across all taps, and coefficients are loaded at run time through a serial shift interface. Output is saturated and handshaked with a valid strobe.

Parameters:
N_TAPS, 4, number of taps / delay-line depth (>=1)
BW_in, 2, signed input sample width
BW_coef, 4, signed coefficient width
BW_out, 8, signed output width (1..ACC_W)
SHIFT, 0, arithmetic right shift applied to the accumulator before saturation (0..ACC_W-1)

Ports:
clk  input  1  single system clock, all state updates on its rising edge
rst  input  1  synchronous, active-high reset
x_in  input  BW_in  signed input sample
x_valid  input  1  sample offered
x_ready  output  1  core can accept a sample this cycle
coef_in  input  BW_coef  signed coefficient word
coef_load  input  1  shift coef_in into the coefficient register file
y_out  output  BW_out  signed filtered output, held between results
y_valid  output  1  one-cycle strobe, y_out updated this cycle

Behaviour:
- Reset, synchronous, active-high, clocked on clk:
  - delay line d[0..N-1] = 0, coefficients c[0..N-1] = 0, accumulator = 0
  - y_out = 0, y_valid = 0, state = IDLE, tap index = 0
  - x_ready goes high in the first cycle after rst deasserts.
- Width rule: ACC_W = BW_in + BW_coef + clog2(N_TAPS). All arithmetic is two's complement and sign-extended to ACC_W. The accumulator never wraps for any input.
- States: IDLE, MAC.
- x_ready = (state == IDLE) && !coef_load.
- Coefficient load, IDLE only:
  - On each edge with coef_load=1: c[k] <= c[k+1] for k < N-1, and c[N-1] <= coef_in.
  - After N loads, the first word loaded sits in c[0].
  - coef_load in MAC is ignored; coefficients are stable for the whole MAC pass.
  - coef_load and x_valid together in IDLE: the coefficient shifts and the sample is NOT accepted (x_ready=0).
- Sample accept, on an edge with x_valid && x_ready:
  - d[0] <= x_in, d[k] <= d[k-1]
  - acc <= 0, tap index <= 0, state <= MAC
- MAC, exactly N_TAPS cycles:
  - Each edge: acc += c[i]*d[i], i increments.
  - On the edge processing i = N-1: y_out <= sat(((acc + c[N-1]*d[N-1]) >>> SHIFT), BW_out), y_valid <= 1, state <= IDLE.
- Saturation: clamp to [-2^(BW_out-1), 2^(BW_out-1)-1].
- Latency: if a sample is accepted at edge E0, y_valid is high for the cycle between edges E_N and E_{N+1}.
  - x_ready is low for the N cycles after E0 and is high again in the y_valid cycle, so back-to-back samples are allowed there.
  - Throughput is 1 sample per N_TAPS+1 cycles max.
- y_valid is high for exactly one cycle per accepted sample. y_out holds its value until the next result or reset.
- x_valid while x_ready=0: the sample is dropped (no buffering). The producer must hold it.
- Reset mid-MAC: the pass is aborted, no y_valid is produced, and all state is cleared as above.
- N_TAPS=1: one MAC cycle; the output appears in the cycle after the cycle following accept.

Test Plan:
1. Reset, default parameters: assert rst 2 cycles, release -> y_out=0, y_valid=0, x_ready=1; an impulse fed with no coefficients loaded -> y_out=0, y_valid pulses.
2. Load coefficients 1,2,3,4 (c0=1..c3=4), then feed x=1,0,0,0,0 -> y_out sequence 1,2,3,4,0. With x=-2,0,0,0 -> -2,-4,-6,-8.
3. Latency/handshake, N_TAPS=4: accept at edge 0 -> x_ready low for the 4 following cycles, y_valid high only in cycle 4. A new sample presented in the y_valid cycle is accepted. Holding x_valid continuously yields a result every 5 cycles.
4. Saturation with BW_out=4: coefficients 7,7,7,7; x=1 four times -> 4th output 28 clamps to 7. x=-2 four times -> -56 clamps to -8. With SHIFT=2 and BW_out=8, x=1 x4 -> 7.
5. Priority/ignore:
   - coef_load asserted during MAC -> coefficients unchanged and the result matches scenario 2.
   - coef_load and x_valid in the same IDLE cycle -> coefficient shifted, x_ready=0, sample not consumed.
6. Reset mid-operation: rst at the 2nd MAC cycle -> no y_valid, y_out=0. A subsequent impulse with reloaded coefficients 1,2,3,4 gives 1,2,3,4 with no residue from the old delay line.
